// File: rtl/lighting_pkg.sv
// lighting_pkg: shared types for the lighting scheduler.
//   vec3_t        - fp16 {x,y,z} vector (48b)
//   tri_t         - triangle {v0,v1,v2} (144b)
//   rgb_t         - colour {r,g,b} (24b)
//   sched_state_t - scheduler FSM states
//   LIGHT_LATENCY - lighting unit latency from lt_en to lt_valid
package lighting_pkg;
    typedef logic [47:0]  vec3_t;
    typedef logic [143:0] tri_t;
    typedef logic [23:0]  rgb_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} sched_state_t;

    localparam int LIGHT_LATENCY = 9;
endpackage

// File: rtl/lighting_sched_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (count resets to 0)
//   clr        - synchronous clear, wins over inc
//   inc        - increment by one unless already saturated
//   cnt        - current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != '1))
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/lighting_sched.sv
// lighting_sched: sequencer for the single, non-pipelined lighting unit.
// Takes one triangle at a time, launches a lighting job with a one-cycle
// lt_en pulse, holds the operands until the job resolves, and forwards lit
// triangles downstream with their shaded colour. Culled and timed-out jobs
// are dropped. Owns the light-vector config register.
// Ports:
//   in_valid/in_ready/in_tri/in_rgb      - upstream triangle handshake
//   cfg_lv_wr/cfg_lv                     - light-vector config write
//   lt_en/lt_triangle/lt_light_vec/lt_rgb - lighting unit launch + operands
//   lt_valid/lt_illuminated/lt_out_rgb   - lighting unit result
//   out_valid/out_ready/out_tri/out_rgb  - downstream handshake
//   busy, timeout_err (sticky)           - status
// Build option: define LIGHT_STATS_EN to add stat_lit/stat_culled/
// stat_timeout saturating job-outcome counters.
module lighting_sched
    import lighting_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [143:0]  in_tri,
    input  logic [23:0]   in_rgb,
    input  logic          cfg_lv_wr,
    input  logic [47:0]   cfg_lv,
    output logic          lt_en,
    output logic [143:0]  lt_triangle,
    output logic [47:0]   lt_light_vec,
    output logic [23:0]   lt_rgb,
    input  logic          lt_valid,
    input  logic          lt_illuminated,
    input  logic [23:0]   lt_out_rgb,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [143:0]  out_tri,
    output logic [23:0]   out_rgb,
    output logic          busy,
    output logic          timeout_err
`ifdef LIGHT_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_lit,
    output logic [CNT_W-1:0] stat_culled,
    output logic [CNT_W-1:0] stat_timeout
`endif
);
    // A watchdog shorter than the unit's own latency would abandon every job.
    localparam int TO_CYC = (TIMEOUT_CYC > LIGHT_LATENCY) ? TIMEOUT_CYC : LIGHT_LATENCY + 1;
    localparam int WD_W   = $clog2(TO_CYC + 1);

    sched_state_t    state_q, state_d;
    tri_t            op_tri_q, op_tri_d;
    rgb_t            op_rgb_q, op_rgb_d;
    rgb_t            res_rgb_q, res_rgb_d;
    vec3_t           lv_q, lv_d;
    vec3_t           pend_lv_q, pend_lv_d;
    logic            pend_q, pend_d;
    logic            timeout_err_q, timeout_err_d;
    logic            in_ready_q, in_ready_d;
    logic            lt_en_q, lt_en_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic [WD_W-1:0] wd_cnt;
    logic            job_lit, job_cull, job_to;

    // Watchdog: cleared on issue, counts every WAIT cycle.
    sat_counter #(.W(WD_W)) u_wd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == ISSUE),
        .inc   (state_q == WAIT),
        .cnt   (wd_cnt)
    );

    assign job_lit  = (state_q == WAIT) && lt_valid && lt_illuminated;
    assign job_cull = (state_q == WAIT) && lt_valid && !lt_illuminated;
    // Count is 0 on the first WAIT cycle, so TO_CYC-1 is the last allowed one.
    assign job_to   = (state_q == WAIT) && !lt_valid && (wd_cnt == WD_W'(TO_CYC - 1));

    always_comb begin
        state_d       = state_q;
        op_tri_d      = op_tri_q;
        op_rgb_d      = op_rgb_q;
        res_rgb_d     = res_rgb_q;
        lv_d          = lv_q;
        pend_lv_d     = pend_lv_q;
        pend_d        = pend_q;
        timeout_err_d = timeout_err_q | job_to;

        // Light vector only changes in IDLE so an in-flight job keeps its
        // operand; writes while busy park in the pending slot (last wins).
        if (state_q == IDLE) begin
            if (cfg_lv_wr)   lv_d = cfg_lv;
            else if (pend_q) lv_d = pend_lv_q;
            pend_d = 1'b0;
        end else if (cfg_lv_wr) begin
            pend_d    = 1'b1;
            pend_lv_d = cfg_lv;
        end

        case (state_q)
            IDLE: if (in_valid) begin
                op_tri_d = in_tri;
                op_rgb_d = in_rgb;
                state_d  = ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (lt_valid) begin
                    res_rgb_d = lt_out_rgb;
                    state_d   = lt_illuminated ? OUT : IDLE;
                end else if (job_to) begin
                    state_d = IDLE;
                end
            end
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Handshake/status outputs are registered off the next state.
        in_ready_d  = (state_d == IDLE);
        lt_en_d     = (state_d == ISSUE);
        out_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_tri_q      <= '0;
            op_rgb_q      <= '0;
            res_rgb_q     <= '0;
            lv_q          <= '0;
            pend_lv_q     <= '0;
            pend_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            in_ready_q    <= 1'b1;
            lt_en_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_tri_q      <= op_tri_d;
            op_rgb_q      <= op_rgb_d;
            res_rgb_q     <= res_rgb_d;
            lv_q          <= lv_d;
            pend_lv_q     <= pend_lv_d;
            pend_q        <= pend_d;
            timeout_err_q <= timeout_err_d;
            in_ready_q    <= in_ready_d;
            lt_en_q       <= lt_en_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign lt_en        = lt_en_q;
    assign lt_triangle  = op_tri_q;
    assign lt_rgb       = op_rgb_q;
    assign lt_light_vec = lv_q;
    assign out_valid    = out_valid_q;
    assign out_tri      = op_tri_q;
    assign out_rgb      = res_rgb_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;

`ifdef LIGHT_STATS_EN
    sat_counter #(.W(CNT_W)) u_stat_lit (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(job_lit), .cnt(stat_lit));
    sat_counter #(.W(CNT_W)) u_stat_culled (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(job_cull), .cnt(stat_culled));
    sat_counter #(.W(CNT_W)) u_stat_timeout (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(job_to), .cnt(stat_timeout));
`else
    // Outcome strobes and the counter width only feed the stats build.
    logic unused_stats;
    assign unused_stats = job_lit | job_cull | (CNT_W > 0);
`endif
endmodule

// File: tb/tb_lighting_sched.sv
// Directed bench for lighting_sched. The lighting unit is modelled by
// driving lt_valid/lt_illuminated/lt_out_rgb from each scenario task.
module tb_lighting_sched;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [143:0]  in_tri = '0;
    logic [23:0]   in_rgb = '0;
    logic          cfg_lv_wr = 1'b0;
    logic [47:0]   cfg_lv = '0;
    logic          lt_en;
    logic [143:0]  lt_triangle;
    logic [47:0]   lt_light_vec;
    logic [23:0]   lt_rgb;
    logic          lt_valid = 1'b0;
    logic          lt_illuminated = 1'b0;
    logic [23:0]   lt_out_rgb = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [143:0]  out_tri;
    logic [23:0]   out_rgb;
    logic          busy;
    logic          timeout_err;
`ifdef LIGHT_STATS_EN
    logic [31:0]   stat_lit, stat_culled, stat_timeout;
`endif

    int checks = 0;
    int fails  = 0;

    logic [143:0] tri_a, tri_b, tri_c;
    logic [47:0]  lv_a, lv_b, lv_new, lv_c;

    lighting_sched #(.TIMEOUT_CYC(64), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_tri(in_tri), .in_rgb(in_rgb),
        .cfg_lv_wr(cfg_lv_wr), .cfg_lv(cfg_lv),
        .lt_en(lt_en), .lt_triangle(lt_triangle), .lt_light_vec(lt_light_vec), .lt_rgb(lt_rgb),
        .lt_valid(lt_valid), .lt_illuminated(lt_illuminated), .lt_out_rgb(lt_out_rgb),
        .out_valid(out_valid), .out_ready(out_ready), .out_tri(out_tri), .out_rgb(out_rgb),
        .busy(busy), .timeout_err(timeout_err)
`ifdef LIGHT_STATS_EN
        , .stat_lit(stat_lit), .stat_culled(stat_culled), .stat_timeout(stat_timeout)
`endif
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if ({busy, lt_en, out_valid, timeout_err} !== 4'b0) begin
            fails++; $display("FAIL reset_flags got busy=%b lt_en=%b out_valid=%b timeout_err=%b want all 0", busy, lt_en, out_valid, timeout_err); end
        checks++; if (lt_light_vec !== 48'h0 || lt_triangle !== 144'h0 || out_rgb !== 24'h0) begin
            fails++; $display("FAIL reset_regs got lv=%h rgb=%h want 0", lt_light_vec, out_rgb); end
        rst_n = 1'b1;
        step();
    endtask

    // T1: lit triangle, result after 12 cycles.
    task automatic test_lit();
        int en_cnt;
        en_cnt = 0;
        in_valid = 1'b1; in_tri = tri_a; in_rgb = 24'hFF8040;
        step();
        in_valid = 1'b0;
        checks++; if (lt_en !== 1'b1) begin fails++; $display("FAIL lit_lt_en got %b want 1", lt_en); end
        checks++; if (lt_triangle !== tri_a || lt_rgb !== 24'hFF8040) begin
            fails++; $display("FAIL lit_operands got rgb=%h want ff8040", lt_rgb); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL lit_busy got in_ready=%b busy=%b want 0/1", in_ready, busy); end
        en_cnt += lt_en ? 1 : 0;
        repeat (11) begin step(); en_cnt += lt_en ? 1 : 0; end
        lt_valid = 1'b1; lt_illuminated = 1'b1; lt_out_rgb = 24'h7F4020;
        step();
        lt_valid = 1'b0; lt_illuminated = 1'b0; lt_out_rgb = '0;
        checks++; if (en_cnt !== 1) begin fails++; $display("FAIL lit_en_pulses got %0d want 1", en_cnt); end
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL lit_out_valid got %b want 1", out_valid); end
        checks++; if (out_rgb !== 24'h7F4020) begin fails++; $display("FAIL lit_out_rgb got %h want 7f4020", out_rgb); end
        checks++; if (out_tri !== tri_a) begin fails++; $display("FAIL lit_out_tri got %h want %h", out_tri, tri_a); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL lit_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
`ifdef LIGHT_STATS_EN
        checks++; if (stat_lit !== 32'd1) begin fails++; $display("FAIL lit_stat got %0d want 1", stat_lit); end
`endif
    endtask

    // T2: culled triangle is dropped.
    task automatic test_cull();
        in_valid = 1'b1; in_tri = tri_b; in_rgb = 24'h123456;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        lt_valid = 1'b1; lt_illuminated = 1'b0; lt_out_rgb = 24'hABCDEF;
        step();
        lt_valid = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL cull_idle got in_ready=%b busy=%b want 1/0", in_ready, busy); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL cull_out_valid got %b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL cull_out_valid_late got %b want 0", out_valid); end
`ifdef LIGHT_STATS_EN
        checks++; if (stat_culled !== 32'd1) begin fails++; $display("FAIL cull_stat got %0d want 1", stat_culled); end
`endif
    endtask

    // T3: downstream stall for 20+ cycles; a new in_valid must not disturb the held result.
    task automatic test_backpressure();
        in_valid = 1'b1; in_tri = tri_c; in_rgb = 24'h0A0B0C;
        step();
        in_valid = 1'b0;
        step();
        lt_valid = 1'b1; lt_illuminated = 1'b1; lt_out_rgb = 24'h555555;
        step();
        lt_valid = 1'b0; lt_illuminated = 1'b0;
        in_valid = 1'b1; in_tri = tri_a; in_rgb = 24'hFFFFFF;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_tri !== tri_c || out_rgb !== 24'h555555 || in_ready !== 1'b0 || lt_triangle !== tri_c) begin
                fails++; $display("FAIL stall_hold cyc=%0d got out_valid=%b rgb=%h in_ready=%b want 1/555555/0", i, out_valid, out_rgb, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL stall_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    // T4: lighting never answers; watchdog fires 64 cycles after WAIT entry.
    task automatic test_timeout();
        in_valid = 1'b1; in_tri = tri_a; in_rgb = 24'h111111;
        step();
        in_valid = 1'b0;
        step();
        repeat (63) step();
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL to_early got timeout_err=%b busy=%b want 0/1", timeout_err, busy); end
        step();
        checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_flag got %b want 1", timeout_err); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL to_idle got busy=%b in_ready=%b out_valid=%b want 0/1/0", busy, in_ready, out_valid); end
        in_valid = 1'b1; in_tri = tri_b; in_rgb = 24'h010203;
        step();
        in_valid = 1'b0;
        step();
        lt_valid = 1'b1; lt_illuminated = 1'b1; lt_out_rgb = 24'h0F0F0F;
        step();
        lt_valid = 1'b0; lt_illuminated = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_rgb !== 24'h0F0F0F || out_tri !== tri_b) begin
            fails++; $display("FAIL to_next_job got out_valid=%b rgb=%h want 1/0f0f0f", out_valid, out_rgb); end
        checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_sticky got %b want 1", timeout_err); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`ifdef LIGHT_STATS_EN
        checks++; if (stat_timeout !== 32'd1 || stat_lit !== 32'd3) begin
            fails++; $display("FAIL to_stats got timeout=%0d lit=%0d want 1/3", stat_timeout, stat_lit); end
`endif
    endtask

    // T5: light-vector writes while busy are deferred; same-cycle write+accept applies.
    task automatic test_cfg();
        cfg_lv_wr = 1'b1; cfg_lv = lv_a;
        step();
        cfg_lv_wr = 1'b0;
        checks++; if (lt_light_vec !== lv_a) begin fails++; $display("FAIL cfg_idle_wr got %h want %h", lt_light_vec, lv_a); end
        in_valid = 1'b1; in_tri = tri_c; in_rgb = 24'h202020;
        step();
        in_valid = 1'b0;
        step();
        cfg_lv_wr = 1'b1; cfg_lv = lv_b;
        step();
        cfg_lv = lv_new;
        step();
        cfg_lv_wr = 1'b0;
        checks++; if (lt_light_vec !== lv_a) begin fails++; $display("FAIL cfg_busy_hold got %h want %h", lt_light_vec, lv_a); end
        lt_valid = 1'b1; lt_illuminated = 1'b0;
        step();
        lt_valid = 1'b0;
        in_valid = 1'b1; in_tri = tri_a;
        step();
        in_valid = 1'b0;
        checks++; if (lt_en !== 1'b1 || lt_light_vec !== lv_new) begin
            fails++; $display("FAIL cfg_pending got lt_en=%b lv=%h want 1/%h", lt_en, lt_light_vec, lv_new); end
        step();
        lt_valid = 1'b1;
        step();
        lt_valid = 1'b0;
        cfg_lv_wr = 1'b1; cfg_lv = lv_c; in_valid = 1'b1; in_tri = tri_b;
        step();
        cfg_lv_wr = 1'b0; in_valid = 1'b0;
        checks++; if (lt_en !== 1'b1 || lt_light_vec !== lv_c) begin
            fails++; $display("FAIL cfg_same_cycle got lt_en=%b lv=%h want 1/%h", lt_en, lt_light_vec, lv_c); end
        step();
        lt_valid = 1'b1;
        step();
        lt_valid = 1'b0;
    endtask

    // T6: reset in WAIT, then a stray lt_valid.
    task automatic test_reset_mid();
        in_valid = 1'b1; in_tri = tri_b; in_rgb = 24'h777777;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || {busy, lt_en, out_valid, timeout_err} !== 4'b0) begin
            fails++; $display("FAIL rstmid_flags got in_ready=%b busy=%b lt_en=%b out_valid=%b to=%b want 1/0/0/0/0", in_ready, busy, lt_en, out_valid, timeout_err); end
        checks++; if (lt_triangle !== 144'h0 || lt_rgb !== 24'h0 || lt_light_vec !== 48'h0 || out_rgb !== 24'h0) begin
            fails++; $display("FAIL rstmid_regs got rgb=%h lv=%h out_rgb=%h want 0", lt_rgb, lt_light_vec, out_rgb); end
        step();
        rst_n = 1'b1;
        step();
        lt_valid = 1'b1; lt_illuminated = 1'b1; lt_out_rgb = 24'hFFFFFF;
        step();
        lt_valid = 1'b0; lt_illuminated = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_rgb !== 24'h0) begin
            fails++; $display("FAIL rstmid_stray got out_valid=%b busy=%b in_ready=%b rgb=%h want 0/0/1/0", out_valid, busy, in_ready, out_rgb); end
        step();
        checks++; if (out_valid !== 1'b0 || lt_en !== 1'b0) begin
            fails++; $display("FAIL rstmid_late got out_valid=%b lt_en=%b want 0/0", out_valid, lt_en); end
    endtask

    initial begin
        tri_a  = {48'h1111_2222_3333, 48'h4444_5555_6666, 48'h7777_8888_9999};
        tri_b  = {48'hAAAA_BBBB_CCCC, 48'hDDDD_EEEE_FFFF, 48'h0123_4567_89AB};
        tri_c  = {48'h3C00_3C00_3C00, 48'hBC00_0000_3800, 48'h0000_4000_C000};
        lv_a   = 48'h4000_4000_4000;
        lv_b   = 48'h1111_1111_1111;
        lv_new = 48'h3C00_0000_0000;
        lv_c   = 48'h3800_3400_3000;
        test_reset();
        test_lit();
        test_cull();
        test_backpressure();
        test_timeout();
        test_cfg();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
